// File: rtl/display_pkg.sv
// Shared constants and types for the two-digit seven-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } digit_t;

  typedef struct packed {
    logic [6:0] tens;
    logic [6:0] ones;
  } seg_pair_t;

endpackage

// File: rtl/display_scan_driver_if.sv
// Bundle between the decode stage / display pins and display_scan_driver.
// in_val is a fire-and-forget strobe: there is no ready, every strobe is
// accepted on the rising edge where it is high, and a later strobe
// overwrites an earlier uncommitted one.
// The slave modport also exposes the scan FSM state for observation.
interface display_scan_driver_if;
  import display_pkg::*;

  logic       en;
  logic       in_val;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic [6:0] disp_seg;
  logic [1:0] disp_an;
  logic       frame_done;
  logic       pending;
  digit_t     state;

  modport master (
    output en, in_val, seg_tens, seg_ones,
    input  disp_seg, disp_an, frame_done, pending, state
  );

  modport slave (
    input  en, in_val, seg_tens, seg_ones,
    output disp_seg, disp_an, frame_done, pending, state
  );
endinterface

// File: rtl/display_tick_gen.sv
// Digit dwell counter: counts PRESCALE cycles per digit while en is high
// and flags the last cycle of each dwell. Frozen while en is low.
module display_tick_gen #(
  parameter  int PRESCALE = 4,
  localparam int CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Dwell counter, wraps to zero on the last cycle of a dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexes a tens/ones segment pair onto one shared segment bus
// with two active-low anodes. New values go to a shadow register and are
// moved to the active register only at the end of a frame (end of the
// tens dwell), so one frame never shows digits from two different values.
// Optional build macro: BLANK_LEADING_ZERO_EN -- blank the tens digit
// when it shows zero.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input logic                     clk,
  input logic                     rst,
  display_scan_driver_if.slave    bus
);

  digit_t    state_q, state_d;
  seg_pair_t active_q, shadow_q;
  logic      pending_q;
  logic      tick;
  logic      frame_end;
  logic [6:0] tens_view;

  display_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  assign frame_end = tick & (state_q == DIG_TENS);

  // Scan FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIG_ONES;
    else     state_q <= state_d;
  end

  // Scan FSM next state: swap digit at the end of each dwell
  always_comb begin
    state_d = state_q;
    if (tick) state_d = (state_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
  end

  // Shadow capture and frame-boundary commit; commit reads the pre-edge shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= '{tens: SEG_BLANK, ones: SEG_BLANK};
      shadow_q  <= '{tens: SEG_BLANK, ones: SEG_BLANK};
      pending_q <= 1'b0;
    end else begin
      if (frame_end && pending_q) active_q <= shadow_q;
      if (bus.in_val) begin
        shadow_q  <= '{tens: bus.seg_tens, ones: bus.seg_ones};
        pending_q <= 1'b1;
      end else if (frame_end) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Moore outputs: anode and segment mux selected by registered state
  always_comb begin
`ifdef BLANK_LEADING_ZERO_EN
    tens_view = (active_q.tens == SEG_ZERO) ? SEG_BLANK : active_q.tens;
`else
    tens_view = active_q.tens;
`endif
    bus.disp_an    = AN_OFF;
    bus.disp_seg   = active_q.ones;
    bus.frame_done = frame_end;
    bus.pending    = pending_q;
    bus.state      = state_q;
    if (state_q == DIG_TENS) begin
      bus.disp_seg = tens_view;
      if (bus.en) bus.disp_an = AN_TENS;
    end else begin
      if (bus.en) bus.disp_an = AN_ONES;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver (PRESCALE=4). A behavioural model advances
// alongside the stimulus; each cycle's expected {an, seg, frame_done,
// pending} is queued and compared after the DUT clock edge.
module tb_display_scan_driver;
  localparam int P = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  display_scan_driver_if bus ();

  display_scan_driver #(.PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic       m_state;
  int         m_cnt;
  logic [6:0] m_act_t, m_act_o, m_sh_t, m_sh_o;
  logic       m_pend;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_fd();
    return bus.en && m_state && (m_cnt == P - 1);
  endfunction

  // advance the model across one rising edge using the current inputs
  task automatic model_edge();
    logic fd;
    if (rst) begin
      m_state = 1'b0; m_cnt = 0;
      m_act_t = 7'h7F; m_act_o = 7'h7F; m_sh_t = 7'h7F; m_sh_o = 7'h7F;
      m_pend = 1'b0;
    end else begin
      fd = model_fd();
      if (fd && m_pend) begin
        m_act_t = m_sh_t; m_act_o = m_sh_o; m_pend = 1'b0;
      end
      if (bus.in_val) begin
        m_sh_t = bus.seg_tens; m_sh_o = bus.seg_ones; m_pend = 1'b1;
      end
      if (bus.en) begin
        if (m_cnt == P - 1) begin
          m_cnt = 0; m_state = ~m_state;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  function automatic logic [10:0] model_out();
    logic [1:0] an;
    logic [6:0] seg;
    logic [6:0] t;
    t = m_act_t;
`ifdef BLANK_LEADING_ZERO_EN
    if (t == 7'h40) t = 7'h7F;
`endif
    an  = !bus.en ? 2'b11 : (m_state ? 2'b01 : 2'b10);
    seg = m_state ? t : m_act_o;
    return {an, seg, model_fd(), m_pend};
  endfunction

  // driver: one clock cycle with the inputs currently applied
  task automatic step();
    logic [10:0] e;
    model_edge();
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("cyc", {bus.disp_an, bus.disp_seg, bus.frame_done, bus.pending}, e);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic capture(input logic [6:0] t, input logic [6:0] o);
    bus.in_val = 1'b1; bus.seg_tens = t; bus.seg_ones = o;
    step();
    bus.in_val = 1'b0;
  endtask

  // step until the model says the next edge ends a frame (bounded)
  task automatic to_frame_end();
    int n;
    n = 0;
    while (!model_fd() && n < 4 * P) begin
      step(); n++;
    end
    if (!model_fd()) check("frame_end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b1; bus.in_val = 1'b0;
    bus.seg_tens = 7'h00; bus.seg_ones = 7'h00;
    m_state = 1'b0; m_cnt = 0; m_pend = 1'b0;
    m_act_t = 7'h7F; m_act_o = 7'h7F; m_sh_t = 7'h7F; m_sh_o = 7'h7F;

    // reset
    steps(2);
    check("reset_an", {30'd0, bus.disp_an}, 32'h2);
    check("reset_seg", {25'd0, bus.disp_seg}, 32'h7F);
    check("reset_pending", {31'd0, bus.pending}, 32'd0);
    rst = 1'b0;

    // 1: free-running blank scan, two frames
    steps(4 * P);

    // 2: mid-frame capture of "12", shown from next frame
    steps(2);
    capture(7'h79, 7'h24);
    check("pending_after_capture", {31'd0, bus.pending}, 32'd1);
    to_frame_end();
    step();
    check("new_ones_shown", {23'd0, bus.disp_an, bus.disp_seg}, {23'd0, 2'b10, 7'h24});
    check("pending_cleared", {31'd0, bus.pending}, 32'd0);
    steps(P);
    check("new_tens_shown", {23'd0, bus.disp_an, bus.disp_seg}, {23'd0, 2'b01, 7'h79});

    // 3: two captures in one frame, last one wins
    step();
    capture(7'h79, 7'h24);
    step();
    capture(7'h30, 7'h19);
    steps(4 * P);

    // 4: capture on the frame_done cycle
    capture(7'h12, 7'h02);
    to_frame_end();
    capture(7'h78, 7'h00);
    check("pending_held", {31'd0, bus.pending}, 32'd1);
    check("old_shadow_committed", {25'd0, bus.disp_seg}, {25'd0, 7'h02});
    steps(4 * P + 2);

    // 5: pause mid-TENS, then reset with a pending capture
    while (!(m_state && m_cnt == 1)) step();
    bus.en = 1'b0;
    steps(5);
    bus.en = 1'b1;
    steps(3 * P);
    capture(7'h79, 7'h79);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_pending", {31'd0, bus.pending}, 32'd0);
    steps(3 * P);

    // 6: leading-zero tens digit
    capture(7'h40, 7'h19);
    steps(4 * P + 2);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      bus.in_val = ($urandom_range(0, 5) == 0);
      bus.seg_tens = 7'($urandom_range(0, 127));
      bus.seg_ones = 7'($urandom_range(0, 127));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; bus.in_val = 1'b0; bus.en = 1'b1;
    steps(2);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
